spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per SPI word.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sclk  input  1  SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port mosi  input  1  SPI master-out data, asynchronous to clk.
REQ-007 SHALL have port miso  output  1  SPI slave-out data.
REQ-008 SHALL have port miso_oe  output  1  MISO output enable; high only while selected.
REQ-009 SHALL have port tx_data  input  WIDTH  next word to transmit.
REQ-010 SHALL have port tx_valid  input  1  tx_data offered.
REQ-011 SHALL have port tx_ready  output  1  transmit buffer empty; accepts tx_data.
REQ-012 SHALL have port rx_data  output  WIDTH  last complete received word.
REQ-013 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-014 SHALL have port tx_underrun  output  1  one-cycle pulse: word started with empty buffer.

Function
REQ-015 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Sample mosi on sclk rising.
- Change miso after sclk falling.
REQ-016 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers.
- Edges detected from synchronized stage 2 against a third flop.
- An event at a pin takes effect at the 3rd clk rising edge after it.
REQ-017 SHALL require sclk high and low phases of at least 3 clk periods; behaviour is undefined otherwise.
REQ-018 SHALL have two states, IDLE and SHIFT.
- IDLE->SHIFT on synchronized cs_n falling edge.
- SHIFT->IDLE on synchronized cs_n rising edge.
REQ-019 On IDLE->SHIFT, SHALL load the tx shift register and set bit_count=0.
- Buffer full: load buffer, mark buffer empty.
- Buffer empty: load all zeros and pulse tx_underrun.
REQ-020 SHALL drive miso = MSB of the tx shift register at all times.
- miso_oe=1 in SHIFT, 0 in IDLE.
REQ-021 In SHIFT, on each sclk rising: SHALL shift mosi into the rx shift register LSB and increment bit_count.
REQ-022 When bit_count reaches WIDTH on an sclk rising: SHALL, in the same update,
- copy the assembled word to rx_data,
- pulse rx_valid for exactly one cycle,
- reset bit_count to 0.
REQ-023 In SHIFT, on each sclk falling with bit_count!=0: SHALL shift the tx register left one bit, filling with 0.
REQ-024 On an sclk falling with bit_count=0 after at least one completed word: SHALL reload the tx register per REQ-019 for back-to-back words.
REQ-025 Transmit buffer handshake:
- tx_ready = buffer empty.
- Buffer captures tx_data when tx_valid and tx_ready are both high.
- Holds one word.
REQ-026 Buffer capture and buffer consumption in the same cycle: SHALL perform the consume first, then the capture, so the new word is kept and no word is lost.
REQ-027 cs_n rising mid-word (bit_count 1..WIDTH-1): SHALL discard the partial word.
- No rx_valid.
- rx_data unchanged.
- bit_count=0, return to IDLE.
- Untransmitted tx bits are dropped; the buffer is not refilled from them.
REQ-028 SHALL ignore sclk edges while in IDLE.
REQ-029 rx_data SHALL hold its value until the next completed word; no rx back-pressure exists.

Reset
REQ-030 While reset is high: SHALL set state=IDLE, bit_count=0, both shift registers 0, buffer empty.
REQ-031 While reset is high: SHALL set outputs miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0.
REQ-032 Reset asserted mid-transfer: SHALL abort immediately with no rx_valid.

Verification
REQ-033 Preload tx_data=8'hA5, assert cs_n low, master sends 8'h3C over 8 sclk cycles -> master receives 8'hA5; rx_data=8'h3C; one rx_valid pulse; tx_ready returns to 1 at cs_n-fall load.
REQ-034 Two back-to-back words with buffer refilled between them (8'h01 then 8'h80) -> miso yields 8'h01, 8'h80; two rx_valid pulses; no tx_underrun.
REQ-035 cs_n low with empty buffer -> tx_underrun pulses once; miso=0 for all 8 bits.
REQ-036 cs_n released after 5 sclk cycles -> no rx_valid; rx_data keeps prior value; miso_oe=0 in IDLE.
REQ-037 sclk toggled 8 times with cs_n high -> rx_valid never asserts; bit_count stays 0.
REQ-038 reset pulsed after 3 bits -> all outputs at reset values; a following full 8-bit transfer completes correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 (CPOL=0, CPHA=0), MSB-first slave with a one-word
// transmit buffer. All SPI pins are synchronized into the clk domain.
// The shifting logic runs entirely on clk, using the detected sclk and
// cs_n edges.
module spi_slave #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             tx_underrun
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Shift a word left by one position, inserting a new LSB.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] vec,
                                                 input logic             lsb);
      shift_in = {vec[WIDTH-2:0], lsb};
   endfunction

   // Synchronizer chains. Bit 0 is stage 1, bit 1 is stage 2 and bit 2 is
   // the extra flop used only for edge detection.
   logic [2:0]       r_sclk_sync;
   logic [2:0]       r_cs_sync;
   logic [1:0]       r_mosi_sync;

   // Transmit buffer
   logic [WIDTH-1:0] r_buf;
   logic             r_buf_empty;

   // Transfer state
   state_t           r_state;
   logic [CW-1:0]    r_bit_count;
   logic             r_word_done;
   logic             r_pend_underrun;
   logic [WIDTH-1:0] r_tx_shift;
   logic [WIDTH-1:0] r_rx_shift;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;
   logic             r_tx_underrun;
   logic             r_miso_oe;

   // Decoded events
   logic             w_sclk_rise;
   logic             w_sclk_fall;
   logic             w_cs_fall;
   logic             w_cs_rise;
   logic             w_mosi;
   logic             w_start;
   logic             w_reload;
   logic             w_load;
   logic [WIDTH-1:0] w_load_word;

   // Bring the asynchronous SPI pins into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sclk_sync <= 3'b000;
         r_cs_sync   <= 3'b111;
         r_mosi_sync <= 2'b00;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], sclk};
         r_cs_sync   <= {r_cs_sync[1:0], cs_n};
         r_mosi_sync <= {r_mosi_sync[0], mosi};
      end
   end

   // Decode pin edges and the transmit-register load events.
   always_comb begin
      w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
      w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
      w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
      w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];
      w_mosi      = r_mosi_sync[1];
      w_start     = (r_state == ST_IDLE) & w_cs_fall;
      w_reload    = (r_state == ST_SHIFT) & ~w_cs_rise & w_sclk_fall &
                    (r_bit_count == {CW{1'b0}}) & r_word_done;
      w_load      = w_start | w_reload;
      if (r_buf_empty) begin
         w_load_word = {WIDTH{1'b0}};
      end else begin
         w_load_word = r_buf;
      end
   end

   // One-word transmit buffer. A load consumes the buffer; a capture in the
   // same cycle is only possible when the buffer was already empty, so the
   // load takes zeros and the newly offered word is kept for the next load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf       <= {WIDTH{1'b0}};
         r_buf_empty <= 1'b1;
      end else if (r_buf_empty && tx_valid) begin
         r_buf       <= tx_data;
         r_buf_empty <= 1'b0;
      end else if (w_load) begin
         r_buf_empty <= 1'b1;
      end else begin
         r_buf_empty <= r_buf_empty;
      end
   end

   // Transfer FSM: framing on cs_n, rx on sclk rising, tx on sclk falling.
   // A back-to-back reload from an empty buffer happens at the falling edge
   // that ends a word, before it is known whether the master continues; its
   // underrun is therefore held pending and reported only when the next
   // word actually begins with its first sclk rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_bit_count     <= {CW{1'b0}};
         r_word_done     <= 1'b0;
         r_pend_underrun <= 1'b0;
         r_tx_shift      <= {WIDTH{1'b0}};
         r_rx_shift      <= {WIDTH{1'b0}};
         r_rx_data       <= {WIDTH{1'b0}};
         r_rx_valid      <= 1'b0;
         r_tx_underrun   <= 1'b0;
         r_miso_oe       <= 1'b0;
      end else begin
         r_rx_valid    <= 1'b0;
         r_tx_underrun <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state         <= ST_SHIFT;
                  r_miso_oe       <= 1'b1;
                  r_bit_count     <= {CW{1'b0}};
                  r_word_done     <= 1'b0;
                  r_pend_underrun <= 1'b0;
                  r_rx_shift      <= {WIDTH{1'b0}};
                  r_tx_shift      <= w_load_word;
                  r_tx_underrun   <= r_buf_empty;
               end else begin
                  r_miso_oe <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (w_cs_rise) begin
                  r_state         <= ST_IDLE;
                  r_miso_oe       <= 1'b0;
                  r_bit_count     <= {CW{1'b0}};
                  r_pend_underrun <= 1'b0;
                  r_tx_shift      <= {WIDTH{1'b0}};
                  r_rx_shift      <= {WIDTH{1'b0}};
               end else if (w_sclk_rise) begin
                  r_rx_shift <= shift_in(r_rx_shift, w_mosi);
                  if (r_pend_underrun && (r_bit_count == {CW{1'b0}})) begin
                     r_tx_underrun   <= 1'b1;
                     r_pend_underrun <= 1'b0;
                  end else begin
                     r_pend_underrun <= r_pend_underrun;
                  end
                  if (r_bit_count == CW'(WIDTH - 1)) begin
                     r_rx_data   <= shift_in(r_rx_shift, w_mosi);
                     r_rx_valid  <= 1'b1;
                     r_bit_count <= {CW{1'b0}};
                     r_word_done <= 1'b1;
                  end else begin
                     r_bit_count <= r_bit_count + CW'(1);
                  end
               end else if (w_sclk_fall) begin
                  if (r_bit_count != {CW{1'b0}}) begin
                     r_tx_shift <= shift_in(r_tx_shift, 1'b0);
                  end else if (r_word_done) begin
                     r_tx_shift      <= w_load_word;
                     r_pend_underrun <= r_buf_empty;
                  end else begin
                     r_tx_shift <= r_tx_shift;
                  end
               end else begin
                  r_state <= r_state;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_miso_oe   <= 1'b0;
               r_bit_count <= {CW{1'b0}};
               r_tx_shift  <= {WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign miso        = r_tx_shift[WIDTH-1];
   assign miso_oe     = r_miso_oe;
   assign tx_ready    = r_buf_empty;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks for spi_slave (WIDTH=8), acting as a mode-0
// SPI master with sclk phases of 5 clk periods.
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;

   int n_checks = 0;
   int n_pass   = 0;
   int rx_cycles  = 0;
   int und_cycles = 0;

   spi_slave #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun)
   );

   always #5 clk = ~clk;

   // Count clk cycles in which each pulse output is high.
   always @(posedge clk) begin
      if (rx_valid === 1'b1) rx_cycles <= rx_cycles + 1;
      if (tx_underrun === 1'b1) und_cycles <= und_cycles + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic preload(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Send the low nbits of m MSB first; s collects miso sampled at each rise.
   task automatic send_bits(input logic [15:0] m, input int nbits, output logic [15:0] s);
      s = 16'h0000;
      for (int i = 0; i < nbits; i++) begin
         mosi = m[nbits-1-i];
         wait_clk(5);
         s = {s[14:0], miso};
         sclk = 1'b1;
         wait_clk(5);
         sclk = 1'b0;
      end
      wait_clk(5);
   endtask

   task automatic test_reset;
      reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0;
      wait_clk(3);
      n_checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else n_pass++;
      n_checks++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); else n_pass++;
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); else n_pass++;
      n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
      n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
      n_checks++; if (tx_underrun !== 1'b0) $display("FAIL reset_tx_underrun: got %b expected 0", tx_underrun); else n_pass++;
      reset = 1'b0;
      wait_clk(4);
   endtask

   task automatic test_basic;
      logic [15:0] s;
      int rx0, u0;
      preload(8'hA5);
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL basic_ready_full: got %b expected 0", tx_ready); else n_pass++;
      rx0 = rx_cycles; u0 = und_cycles;
      cs_n = 1'b0;
      wait_clk(5);
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL basic_ready_after_load: got %b expected 1", tx_ready); else n_pass++;
      n_checks++; if (miso_oe !== 1'b1) $display("FAIL basic_oe_selected: got %b expected 1", miso_oe); else n_pass++;
      send_bits(16'h003C, 8, s);
      n_checks++; if (s[7:0] !== 8'hA5) $display("FAIL basic_miso_word: got %h expected a5", s[7:0]); else n_pass++;
      cs_n = 1'b1;
      wait_clk(6);
      n_checks++; if (rx_data !== 8'h3C) $display("FAIL basic_rx_data: got %h expected 3c", rx_data); else n_pass++;
      n_checks++; if (rx_cycles - rx0 !== 1) $display("FAIL basic_rx_valid_cycles: got %0d expected 1", rx_cycles - rx0); else n_pass++;
      n_checks++; if (und_cycles - u0 !== 0) $display("FAIL basic_underrun: got %0d expected 0", und_cycles - u0); else n_pass++;
      n_checks++; if (miso_oe !== 1'b0) $display("FAIL basic_oe_idle: got %b expected 0", miso_oe); else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] s;
      int rx0, u0;
      preload(8'h01);
      rx0 = rx_cycles; u0 = und_cycles;
      cs_n = 1'b0;
      wait_clk(5);
      preload(8'h80);
      n_checks++; if (tx_ready !== 1'b0) $display("FAIL b2b_refill_ready: got %b expected 0", tx_ready); else n_pass++;
      send_bits(16'h5AC3, 16, s);
      n_checks++; if (s !== 16'h0180) $display("FAIL b2b_miso_words: got %h expected 0180", s); else n_pass++;
      cs_n = 1'b1;
      wait_clk(6);
      n_checks++; if (rx_data !== 8'hC3) $display("FAIL b2b_rx_data: got %h expected c3", rx_data); else n_pass++;
      n_checks++; if (rx_cycles - rx0 !== 2) $display("FAIL b2b_rx_valid_cycles: got %0d expected 2", rx_cycles - rx0); else n_pass++;
      n_checks++; if (und_cycles - u0 !== 0) $display("FAIL b2b_underrun: got %0d expected 0", und_cycles - u0); else n_pass++;
   endtask

   task automatic test_underrun;
      logic [15:0] s;
      int u0;
      u0 = und_cycles;
      cs_n = 1'b0;
      wait_clk(5);
      n_checks++; if (und_cycles - u0 !== 1) $display("FAIL und_pulse_at_start: got %0d expected 1", und_cycles - u0); else n_pass++;
      send_bits(16'h0096, 8, s);
      n_checks++; if (s[7:0] !== 8'h00) $display("FAIL und_miso_zero: got %h expected 00", s[7:0]); else n_pass++;
      cs_n = 1'b1;
      wait_clk(6);
      n_checks++; if (und_cycles - u0 !== 1) $display("FAIL und_pulse_once: got %0d expected 1", und_cycles - u0); else n_pass++;
      n_checks++; if (rx_data !== 8'h96) $display("FAIL und_rx_data: got %h expected 96", rx_data); else n_pass++;
   endtask

   task automatic test_abort;
      logic [15:0] s;
      int rx0;
      rx0 = rx_cycles;
      cs_n = 1'b0;
      wait_clk(5);
      send_bits(16'h0015, 5, s);
      n_checks++; if (miso_oe !== 1'b1) $display("FAIL abort_oe_mid: got %b expected 1", miso_oe); else n_pass++;
      cs_n = 1'b1;
      wait_clk(6);
      n_checks++; if (rx_cycles - rx0 !== 0) $display("FAIL abort_no_rx_valid: got %0d expected 0", rx_cycles - rx0); else n_pass++;
      n_checks++; if (rx_data !== 8'h96) $display("FAIL abort_rx_data_kept: got %h expected 96", rx_data); else n_pass++;
      n_checks++; if (miso_oe !== 1'b0) $display("FAIL abort_oe_idle: got %b expected 0", miso_oe); else n_pass++;
      n_checks++; if (dut.r_bit_count !== 4'd0) $display("FAIL abort_bit_count: got %0d expected 0", dut.r_bit_count); else n_pass++;
   endtask

   task automatic test_idle_sclk;
      int rx0;
      rx0 = rx_cycles;
      for (int i = 0; i < 8; i++) begin
         mosi = i[0];
         wait_clk(5);
         sclk = 1'b1;
         wait_clk(5);
         sclk = 1'b0;
      end
      wait_clk(5);
      n_checks++; if (rx_cycles - rx0 !== 0) $display("FAIL idle_no_rx_valid: got %0d expected 0", rx_cycles - rx0); else n_pass++;
      n_checks++; if (dut.r_bit_count !== 4'd0) $display("FAIL idle_bit_count: got %0d expected 0", dut.r_bit_count); else n_pass++;
      n_checks++; if (miso_oe !== 1'b0) $display("FAIL idle_oe: got %b expected 0", miso_oe); else n_pass++;
      n_checks++; if (rx_data !== 8'h96) $display("FAIL idle_rx_data: got %h expected 96", rx_data); else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [15:0] s;
      int rx0;
      preload(8'h5A);
      rx0 = rx_cycles;
      cs_n = 1'b0;
      wait_clk(5);
      send_bits(16'h0007, 3, s);
      reset = 1'b1;
      wait_clk(2);
      n_checks++; if (miso !== 1'b0) $display("FAIL rmid_miso: got %b expected 0", miso); else n_pass++;
      n_checks++; if (miso_oe !== 1'b0) $display("FAIL rmid_miso_oe: got %b expected 0", miso_oe); else n_pass++;
      n_checks++; if (tx_ready !== 1'b1) $display("FAIL rmid_tx_ready: got %b expected 1", tx_ready); else n_pass++;
      n_checks++; if (rx_data !== 8'h00) $display("FAIL rmid_rx_data: got %h expected 00", rx_data); else n_pass++;
      n_checks++; if (tx_underrun !== 1'b0) $display("FAIL rmid_underrun: got %b expected 0", tx_underrun); else n_pass++;
      cs_n = 1'b1;
      sclk = 1'b0;
      wait_clk(2);
      reset = 1'b0;
      wait_clk(5);
      n_checks++; if (rx_cycles - rx0 !== 0) $display("FAIL rmid_no_rx_valid: got %0d expected 0", rx_cycles - rx0); else n_pass++;
      preload(8'hC3);
      rx0 = rx_cycles;
      cs_n = 1'b0;
      wait_clk(5);
      send_bits(16'h007E, 8, s);
      n_checks++; if (s[7:0] !== 8'hC3) $display("FAIL rmid_after_miso: got %h expected c3", s[7:0]); else n_pass++;
      cs_n = 1'b1;
      wait_clk(6);
      n_checks++; if (rx_data !== 8'h7E) $display("FAIL rmid_after_rx_data: got %h expected 7e", rx_data); else n_pass++;
      n_checks++; if (rx_cycles - rx0 !== 1) $display("FAIL rmid_after_rx_valid: got %0d expected 1", rx_cycles - rx0); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_underrun;
      test_abort;
      test_idle_sclk;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
